// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the PLL reconfiguration controller.
//   pll_state_e : sequencer state encoding
//   RW_DEF      : default divider field width
//   LOSS_W      : width of the saturating lock-loss counter
//   sat_inc     : saturating increment for the lock-loss counter
//   max2        : elaboration-time maximum used to size the shared timer
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        StRstHold  = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StPhase    = 3'd3,
        StReady    = 3'd4,
        StError    = 3'd5
    } pll_state_e;

    localparam int unsigned RW_DEF = 10;
    localparam int unsigned LOSS_W = 8;

    function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
        return (v == '1) ? v : v + LOSS_W'(1);
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser for the asynchronous PLL LOCK output, plus a
// falling-edge detector on the synchronised level.
//   clk       in  : reference clock
//   rst       in  : asynchronous active-high reset
//   lock_raw  in  : raw LOCK from the PLL
//   lock_s    out : synchronised lock level (2 cycles latency)
//   lock_fall out : one-cycle pulse when lock_s goes 1 -> 0
module pll_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic lock_raw,
    output logic lock_s,
    output logic lock_fall
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= lock_raw;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign lock_s    = sync;
    assign lock_fall = sync_d & ~sync;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// Sequencer for a dynamically reconfigurable PLL: power-up lock sequence,
// runtime divider reconfiguration followed by an optional fine phase shift,
// and lock supervision (timeout, retry, error, loss counting).
//   clk, rst            : reference clock, asynchronous active-high reset
//   cfg_valid/ready     : reconfiguration handshake
//   cfg_ratioi/f/o      : requested dividers (ratioo ch0 in LSBs)
//   cfg_phase_ch/dir/cnt: requested phase shift (cnt = 0 or ch >= N_OUT skips it)
//   pll_lock            : raw asynchronous LOCK
//   pll_rst, pll_ratio* : PLL reset and divider ports
//   pll_phase_*         : PLL phase-step ports (step_n is an active-low pulse)
//   locked, busy, err   : status; err is sticky until rst or an accepted cfg
//   lock_loss_cnt       : saturating count of lock drops while locked
module pll_reconfig_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned N_OUT         = 2,
    parameter int unsigned RW            = RW_DEF,
    parameter int unsigned DEF_RATIOI    = 2,
    parameter int unsigned DEF_RATIOF    = 25,
    parameter int unsigned DEF_RATIOO    = 5,
    parameter int unsigned RST_CYCLES    = 64,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned STEP_GAP      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [RW-1:0]         cfg_ratioi,
    input  logic [RW-1:0]         cfg_ratiof,
    input  logic [N_OUT*RW-1:0]   cfg_ratioo,
    input  logic [2:0]            cfg_phase_ch,
    input  logic                  cfg_phase_dir,
    input  logic [7:0]            cfg_phase_cnt,
    input  logic                  pll_lock,
    output logic                  pll_rst,
    output logic [RW-1:0]         pll_ratioi,
    output logic [RW-1:0]         pll_ratiof,
    output logic [N_OUT*RW-1:0]   pll_ratioo,
    output logic [2:0]            pll_phase_sel,
    output logic                  pll_phase_dir,
    output logic                  pll_phase_step_n,
    output logic                  locked,
    output logic                  busy,
    output logic                  err,
    output logic [LOSS_W-1:0]     lock_loss_cnt
);

    // One down-counter serves all timed phases, so size it for the longest.
    localparam int unsigned TMAX = max2(max2(RST_CYCLES, LOCK_TIMEOUT),
                                        max2(STABLE_CYCLES, STEP_GAP));
    localparam int unsigned CW   = $clog2(TMAX + 1);
    localparam int unsigned RTW  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CW-1:0] T_RST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] T_TIMEOUT = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] T_STABLE  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] T_GAP     = CW'(STEP_GAP - 1);

    localparam logic [RW-1:0]       DEF_RI = RW'(DEF_RATIOI);
    localparam logic [RW-1:0]       DEF_RF = RW'(DEF_RATIOF);
    localparam logic [N_OUT*RW-1:0] DEF_RO = {N_OUT{RW'(DEF_RATIOO)}};

    pll_state_e          state;
    logic [CW-1:0]       timer;
    logic [RTW-1:0]      retry;
    logic [7:0]          steps_left;

    // Shadow copy of the latest accepted request; the PLL ports only pick
    // these up while the PLL is held in reset.
    logic [RW-1:0]       shd_ratioi;
    logic [RW-1:0]       shd_ratiof;
    logic [N_OUT*RW-1:0] shd_ratioo;
    logic [2:0]          ph_ch;
    logic                ph_dir;
    logic [7:0]          ph_cnt;

    logic lock_s;
    logic lock_fall;
    logic accept;
    logic ch_ok;
    logic lock_lost;

    pll_lock_sync u_lock_sync (
        .clk      (clk),
        .rst      (rst),
        .lock_raw (pll_lock),
        .lock_s   (lock_s),
        .lock_fall(lock_fall)
    );

    assign accept    = cfg_valid & cfg_ready;
    assign ch_ok     = 32'(cfg_phase_ch) < N_OUT;
    // Level check as well as edge: a drop during PHASE must not leave READY stuck.
    assign lock_lost = lock_fall | ~lock_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= StRstHold;
            timer            <= T_RST;
            retry            <= '0;
            steps_left       <= '0;
            shd_ratioi       <= DEF_RI;
            shd_ratiof       <= DEF_RF;
            shd_ratioo       <= DEF_RO;
            ph_ch            <= '0;
            ph_dir           <= 1'b0;
            ph_cnt           <= '0;
            pll_rst          <= 1'b1;
            pll_ratioi       <= DEF_RI;
            pll_ratiof       <= DEF_RF;
            pll_ratioo       <= DEF_RO;
            pll_phase_sel    <= '0;
            pll_phase_dir    <= 1'b0;
            pll_phase_step_n <= 1'b1;
            cfg_ready        <= 1'b0;
            locked           <= 1'b0;
            busy             <= 1'b1;
            err              <= 1'b0;
            lock_loss_cnt    <= '0;
        end else begin
            pll_phase_step_n <= 1'b1;

            case (state)
                StRstHold: begin
                    pll_rst    <= 1'b1;
                    pll_ratioi <= shd_ratioi;
                    pll_ratiof <= shd_ratiof;
                    pll_ratioo <= shd_ratioo;
                    if (timer == '0) begin
                        state   <= StWaitLock;
                        timer   <= T_TIMEOUT;
                        pll_rst <= 1'b0;
                    end else begin
                        timer <= timer - CW'(1);
                    end
                end

                StWaitLock: begin
                    if (lock_s) begin
                        state <= StStable;
                        timer <= T_STABLE;
                    end else if (timer == '0) begin
                        pll_rst <= 1'b1;
                        if (retry == RTW'(MAX_RETRY)) begin
                            state     <= StError;
                            err       <= 1'b1;
                            busy      <= 1'b0;
                            cfg_ready <= 1'b1;
                        end else begin
                            retry <= retry + RTW'(1);
                            state <= StRstHold;
                            timer <= T_RST;
                        end
                    end else begin
                        timer <= timer - CW'(1);
                    end
                end

                StStable: begin
                    if (!lock_s) begin
                        state <= StWaitLock;
                        timer <= T_TIMEOUT;
                    end else if (timer == '0) begin
                        if (ph_cnt != '0) begin
                            // First pulse issues on entry; the request is consumed
                            // so a later relock does not repeat the shift.
                            state            <= StPhase;
                            pll_phase_sel    <= ph_ch;
                            pll_phase_dir    <= ph_dir;
                            pll_phase_step_n <= 1'b0;
                            steps_left       <= ph_cnt - 8'd1;
                            ph_cnt           <= '0;
                            timer            <= T_GAP;
                        end else begin
                            state     <= StReady;
                            locked    <= 1'b1;
                            busy      <= 1'b0;
                            cfg_ready <= 1'b1;
                        end
                    end else begin
                        timer <= timer - CW'(1);
                    end
                end

                StPhase: begin
                    if (timer == '0) begin
                        if (steps_left == '0) begin
                            state     <= StReady;
                            locked    <= 1'b1;
                            busy      <= 1'b0;
                            cfg_ready <= 1'b1;
                        end else begin
                            pll_phase_step_n <= 1'b0;
                            steps_left       <= steps_left - 8'd1;
                            timer            <= T_GAP;
                        end
                    end else begin
                        timer <= timer - CW'(1);
                    end
                end

                StReady: begin
                    if (lock_lost) begin
                        lock_loss_cnt <= sat_inc(lock_loss_cnt);
                        locked        <= 1'b0;
                        busy          <= 1'b1;
                        cfg_ready     <= 1'b0;
                        retry         <= '0;
                        pll_rst       <= 1'b1;
                        state         <= StRstHold;
                        timer         <= T_RST;
                    end
                end

                StError: begin
                    pll_rst <= 1'b1;
                end

                default: begin
                    state   <= StRstHold;
                    timer   <= T_RST;
                    pll_rst <= 1'b1;
                end
            endcase

            // Accepted request overrides the state logic above (cfg wins over a
            // simultaneous lock loss, which is still counted in StReady).
            if (accept) begin
                shd_ratioi <= cfg_ratioi;
                shd_ratiof <= cfg_ratiof;
                shd_ratioo <= cfg_ratioo;
                ph_ch      <= cfg_phase_ch;
                ph_dir     <= cfg_phase_dir;
                ph_cnt     <= ch_ok ? cfg_phase_cnt : 8'd0;
                retry      <= '0;
                err        <= 1'b0;
                cfg_ready  <= 1'b0;
                locked     <= 1'b0;
                busy       <= 1'b1;
                pll_rst    <= 1'b1;
                state      <= StRstHold;
                timer      <= T_RST;
            end
        end
    end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
module tb_pll_reconfig_ctrl;

    localparam int N_OUT = 2;
    localparam int RW    = 10;
    localparam int RSTC  = 64;
    localparam int TOUT  = 512;
    localparam int STAB  = 32;
    localparam int GAP   = 8;

    typedef struct {
        logic [RW-1:0]       ri;
        logic [RW-1:0]       rf;
        logic [N_OUT*RW-1:0] ro;
        logic [2:0]          ch;
        logic                dir;
        logic [7:0]          cnt;
        int                  pulses;
    } vec_t;

    typedef struct {
        logic [RW-1:0]       ri;
        logic [RW-1:0]       rf;
        logic [N_OUT*RW-1:0] ro;
        int                  pulses;
        logic [2:0]          sel;
        logic                dir;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                cfg_valid = 1'b0;
    logic                cfg_ready;
    logic [RW-1:0]       cfg_ratioi = '0;
    logic [RW-1:0]       cfg_ratiof = '0;
    logic [N_OUT*RW-1:0] cfg_ratioo = '0;
    logic [2:0]          cfg_phase_ch = '0;
    logic                cfg_phase_dir = 1'b0;
    logic [7:0]          cfg_phase_cnt = '0;
    logic                pll_lock = 1'b0;
    logic                pll_rst;
    logic [RW-1:0]       pll_ratioi;
    logic [RW-1:0]       pll_ratiof;
    logic [N_OUT*RW-1:0] pll_ratioo;
    logic [2:0]          pll_phase_sel;
    logic                pll_phase_dir;
    logic                pll_phase_step_n;
    logic                locked;
    logic                busy;
    logic                err;
    logic [7:0]          lock_loss_cnt;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   lk_cnt = 0;
    int   lock_delay = 200;
    logic lock_en = 1'b1;
    logic drop = 1'b0;

    // Monitor state
    exp_t sb_q[$];
    int   pulse_cnt = 0;
    int   last_pulse = -1;
    bit   gap_bad = 0;
    logic [2:0] pulse_sel = '0;
    logic pulse_dir = 1'b0;
    int   rst_falls = 0;
    bit   ratio_chg_bad = 0;

    pll_reconfig_ctrl #(
        .N_OUT        (N_OUT),
        .RW           (RW),
        .DEF_RATIOI   (2),
        .DEF_RATIOF   (25),
        .DEF_RATIOO   (5),
        .RST_CYCLES   (RSTC),
        .LOCK_TIMEOUT (TOUT),
        .STABLE_CYCLES(STAB),
        .MAX_RETRY    (3),
        .STEP_GAP     (GAP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_ratioi      (cfg_ratioi),
        .cfg_ratiof      (cfg_ratiof),
        .cfg_ratioo      (cfg_ratioo),
        .cfg_phase_ch    (cfg_phase_ch),
        .cfg_phase_dir   (cfg_phase_dir),
        .cfg_phase_cnt   (cfg_phase_cnt),
        .pll_lock        (pll_lock),
        .pll_rst         (pll_rst),
        .pll_ratioi      (pll_ratioi),
        .pll_ratiof      (pll_ratiof),
        .pll_ratioo      (pll_ratioo),
        .pll_phase_sel   (pll_phase_sel),
        .pll_phase_dir   (pll_phase_dir),
        .pll_phase_step_n(pll_phase_step_n),
        .locked          (locked),
        .busy            (busy),
        .err             (err),
        .lock_loss_cnt   (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // PLL model: LOCK rises lock_delay cycles after RST is released.
    always @(posedge clk) begin
        if (pll_rst) begin
            lk_cnt   <= 0;
            pll_lock <= 1'b0;
        end else begin
            if (lk_cnt < lock_delay) lk_cnt <= lk_cnt + 1;
            pll_lock <= lock_en && !drop && (lk_cnt >= lock_delay);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_locked(input logic want, input int bound, input string name);
        bit ok;
        ok = 0;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (locked === want) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check(name, 64'(locked), 64'(want));
    endtask

    function automatic exp_t mk_exp(input vec_t v);
        exp_t e;
        e.ri = v.ri; e.rf = v.rf; e.ro = v.ro;
        e.pulses = v.pulses; e.sel = v.ch; e.dir = v.dir;
        return e;
    endfunction

    task automatic apply_cfg(input vec_t v, input bit push);
        bit rdy;
        rdy = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (cfg_ready) begin
                rdy = 1;
                break;
            end
        end
        check("cfg_ready_wait", 64'(rdy), 64'(1));
        cfg_valid = 1'b1;
        cfg_ratioi = v.ri; cfg_ratiof = v.rf; cfg_ratioo = v.ro;
        cfg_phase_ch = v.ch; cfg_phase_dir = v.dir; cfg_phase_cnt = v.cnt;
        if (push) sb_q.push_back(mk_exp(v));
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        check("accept_pll_rst", 64'(pll_rst), 64'(1));
        check("accept_cfg_ready", 64'(cfg_ready), 64'(0));
        check("accept_err", 64'(err), 64'(0));
        @(posedge clk); #1;
        check("ratioi_next_cycle", 64'(pll_ratioi), 64'(v.ri));
    endtask

    // Monitor: step pulses, RST sequences, ratio stability, scoreboard pop on lock.
    initial begin
        logic prev_locked = 1'b0;
        logic prev_pll_rst = 1'b1;
        logic [RW-1:0] p_ri = '0;
        logic [RW-1:0] p_rf = '0;
        logic [N_OUT*RW-1:0] p_ro = '0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (pll_rst) begin
                pulse_cnt = 0;
                last_pulse = -1;
                gap_bad = 0;
            end else if (!pll_phase_step_n) begin
                if (last_pulse >= 0 && (cyc - last_pulse) != GAP) gap_bad = 1;
                last_pulse = cyc;
                pulse_cnt++;
                pulse_sel = pll_phase_sel;
                pulse_dir = pll_phase_dir;
            end
            if (!rst && prev_pll_rst && !pll_rst) rst_falls++;
            if (!rst && !pll_rst && !prev_pll_rst &&
                (pll_ratioi !== p_ri || pll_ratiof !== p_rf || pll_ratioo !== p_ro))
                ratio_chg_bad = 1;
            if (locked && !prev_locked && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_ratioi", 64'(pll_ratioi), 64'(e.ri));
                check("sb_ratiof", 64'(pll_ratiof), 64'(e.rf));
                check("sb_ratioo", 64'(pll_ratioo), 64'(e.ro));
                check("sb_pulses", 64'(pulse_cnt), 64'(e.pulses));
                if (e.pulses > 0) begin
                    check("sb_phase_sel", 64'(pulse_sel), 64'(e.sel));
                    check("sb_phase_dir", 64'(pulse_dir), 64'(e.dir));
                end
                if (e.pulses > 1) check("sb_step_gap", 64'(gap_bad), 64'(0));
            end
            prev_locked = locked;
            prev_pll_rst = pll_rst;
            p_ri = pll_ratioi; p_rf = pll_ratiof; p_ro = pll_ratioo;
        end
    end

    initial begin
        vec_t vecs[4];
        vec_t dflt;
        int   n;
        bit   seen;
        int   lows;

        vecs[0] = '{ri: 10'd1, rf: 10'd20, ro: {10'd8, 10'd4},  ch: 3'd1, dir: 1'b1,
                    cnt: 8'd3, pulses: 3};
        vecs[1] = '{ri: 10'd3, rf: 10'd30, ro: {10'd7, 10'd6},  ch: 3'd0, dir: 1'b0,
                    cnt: 8'd1, pulses: 1};
        vecs[2] = '{ri: 10'd2, rf: 10'd40, ro: {10'd9, 10'd9},  ch: 3'd2, dir: 1'b1,
                    cnt: 8'd5, pulses: 0};
        vecs[3] = '{ri: 10'd4, rf: 10'd50, ro: {10'd12, 10'd10}, ch: 3'd1, dir: 1'b0,
                    cnt: 8'd0, pulses: 0};
        dflt    = '{ri: 10'd2, rf: 10'd25, ro: {10'd5, 10'd5}, ch: 3'd0, dir: 1'b0,
                    cnt: 8'd0, pulses: 0};

        // 1. Reset values and default power-up sequence
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_pll_rst", 64'(pll_rst), 64'(1));
        check("rst_ratioi", 64'(pll_ratioi), 64'(2));
        check("rst_ratiof", 64'(pll_ratiof), 64'(25));
        check("rst_ratioo", 64'(pll_ratioo), 64'({10'd5, 10'd5}));
        check("rst_misc", 64'({pll_phase_sel, pll_phase_dir, pll_phase_step_n, cfg_ready,
                               locked, busy, err}), 64'({3'd0, 1'b0, 1'b1, 1'b0, 1'b0,
                               1'b1, 1'b0}));
        check("rst_loss_cnt", 64'(lock_loss_cnt), 64'(0));
        sb_q.push_back(mk_exp(dflt));
        rst = 1'b0;
        n = 0;
        while (pll_rst && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_hold_len", 64'(n), 64'(RSTC));
        n = 0;
        while (!locked && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("lock_latency_ok", 64'(n >= 200 + 2 + STAB - 4 && n <= 200 + 2 + STAB + 6),
              64'(1));
        check("ready_busy", 64'(busy), 64'(0));
        check("ready_cfg_ready", 64'(cfg_ready), 64'(1));

        // 3. Table of reconfiguration requests
        for (int i = 0; i < 4; i++) begin
            apply_cfg(vecs[i], 1'b1);
            wait_locked(1'b1, 2000, "relock_after_cfg");
        end

        // 4. Lock drop for 10 cycles in READY
        @(negedge clk);
        drop = 1'b1;
        sb_q.push_back(mk_exp(vecs[3]));
        n = 0;
        while (pll_lock && n < 10) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (locked && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("loss_unlock_within_3", 64'(n <= 3), 64'(1));
        repeat (8) @(negedge clk);
        drop = 1'b0;
        check("loss_cnt_1", 64'(lock_loss_cnt), 64'(1));
        wait_locked(1'b1, 2000, "relock_after_loss");

        // 5. rst during PHASE after one step
        apply_cfg('{ri: 10'd3, rf: 10'd33, ro: {10'd6, 10'd6}, ch: 3'd1, dir: 1'b1,
                    cnt: 8'd4, pulses: 4}, 1'b0);
        seen = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (!pll_phase_step_n) begin
                seen = 1;
                break;
            end
        end
        check("phase_first_pulse", 64'(seen), 64'(1));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ratios", 64'({pll_ratioi, pll_ratiof, pll_ratioo}),
              64'({10'd2, 10'd25, 10'd5, 10'd5}));
        check("midrst_misc", 64'({pll_rst, pll_phase_sel, pll_phase_step_n, locked, busy,
                                  cfg_ready}), 64'({1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0}));
        lows = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!pll_phase_step_n) lows++;
        end
        check("midrst_no_pulses", 64'(lows), 64'(0));
        sb_q.push_back(mk_exp(dflt));
        rst = 1'b0;
        wait_locked(1'b1, 2000, "relock_after_midrst");

        // 2. Lock never asserts: 1 + MAX_RETRY hold sequences, then error
        @(negedge clk);
        rst = 1'b1;
        lock_en = 1'b0;
        @(negedge clk);
        rst_falls = 0;
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (err) begin
                seen = 1;
                break;
            end
        end
        check("err_reached", 64'(seen), 64'(1));
        check("err_hold_count", 64'(rst_falls), 64'(4));
        check("err_outputs", 64'({pll_rst, cfg_ready, busy, locked}),
              64'({1'b1, 1'b1, 1'b0, 1'b0}));
        repeat (20) @(negedge clk);
        check("err_sticky", 64'({err, pll_rst}), 64'({1'b1, 1'b1}));

        // Recovery from ERROR with a new request; fast lock from here on
        lock_en = 1'b1;
        lock_delay = 5;
        apply_cfg(vecs[1], 1'b1);
        wait_locked(1'b1, 2000, "relock_from_err");

        // 6. Lock-loss counter saturation
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            drop = 1'b1;
            wait_locked(1'b0, 20, "sat_unlock");
            drop = 1'b0;
            wait_locked(1'b1, 1000, "sat_relock");
            if (k == 199) check("loss_cnt_200", 64'(lock_loss_cnt), 64'(200));
        end
        check("loss_cnt_sat", 64'(lock_loss_cnt), 64'(255));

        check("ratio_stable_while_running", 64'(ratio_chg_bad), 64'(0));
        check("scoreboard_empty", 64'(sb_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
